// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles 16-bit words from a valid/ready byte stream,
// writes them into instruction memory and releases the core once the XOR checksum matches.
module imem_boot_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          start,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [15:0]   imem_wdata,
    output logic          core_run,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_e        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    hi_q, hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [AW:0]   words_q, words_d;
    logic [AW:0]   words_inc;
    logic          xfer;

    assign rx_ready  = (state_q == S_HDR) || (state_q == S_HI) ||
                       (state_q == S_LO)  || (state_q == S_CHK);
    assign xfer      = rx_valid && rx_ready;
    assign words_inc = words_q + ONE_W;

    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        csum_d   = csum_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        words_d  = words_q;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        core_run = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_HDR;
            S_HDR: begin
                busy = 1'b1;
                if (xfer) begin
                    if (rx_data == 8'd0 || rx_data > DEPTH_B) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d     = rx_data[AW:0];
                        csum_d  = 8'd0;
                        addr_d  = '0;
                        words_d = '0;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                busy = 1'b1;
                if (xfer) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                busy = 1'b1;
                if (xfer) begin
                    csum_d  = csum_q ^ rx_data;
                    wdata_d = {hi_q, rx_data};
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // The write cycle never consumes a byte: rx_ready is low here.
                busy    = 1'b1;
                imem_we = 1'b1;
                words_d = words_inc;
                if (words_inc == n_q) begin
                    state_d = S_CHK;
                end else begin
                    addr_d  = addr_q + ONE_A;
                    state_d = S_HI;
                end
            end
            S_CHK: begin
                busy = 1'b1;
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                done     = (state_q == S_DONE);
                core_run = (state_q == S_DONE);
                error    = (state_q == S_ERROR);
                if (start) begin
                    words_d = '0;
                    addr_d  = '0;
                    state_d = S_HDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus randomized image loads
// checked against an image-level reference (expected write list and XOR verdict).
module tb_imem_boot_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          core_run;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_run     (core_run),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe seen on the memory port, as {addr, data}.
    logic [20:0] got_q[$];
    always @(negedge clk) begin
        if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
    end

    logic [7:0] img[0:63];
    logic       use_gaps;

    function automatic logic [63:0] all_outs();
        return 64'({rx_ready, imem_we, imem_addr, imem_wdata, core_run, busy, done, error, words_loaded});
    endfunction

    function automatic logic [7:0] img_xor(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < 2 * n; i++) x ^= img[i];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the posedge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        int k;
        if (use_gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
        else @(negedge clk);
    endtask

    task automatic run_load(input int n, input logic [7:0] chk_byte);
        logic [7:0] x;
        logic       ok;
        int         m;
        got_q.delete();
        send_byte(8'(n));
        if (n < 1 || n > DEPTH) begin
            rx_valid = 1'b0;
            check($sformatf("hdr%0d_error", n), 64'(error), 64'd1);
            check($sformatf("hdr%0d_ready", n), 64'(rx_ready), 64'd0);
            check($sformatf("hdr%0d_run", n), 64'(core_run), 64'd0);
            check($sformatf("hdr%0d_no_we", n), 64'(got_q.size()), 64'd0);
            return;
        end
        for (int i = 0; i < 2 * n; i++) send_byte(img[i]);
        send_byte(chk_byte);
        rx_valid = 1'b0;
        x  = img_xor(n);
        ok = (chk_byte == x);
        check("end_done", 64'(done), 64'(ok));
        check("end_error", 64'(error), 64'(!ok));
        check("end_core_run", 64'(core_run), 64'(ok));
        check("end_ready", 64'(rx_ready), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_words", 64'(words_loaded), 64'(n));
        check("end_nwrites", 64'(got_q.size()), 64'(n));
        m = (got_q.size() < n) ? got_q.size() : n;
        for (int i = 0; i < m; i++)
            check($sformatf("write%0d", i), 64'(got_q[i]), 64'({5'(i), img[2*i], img[2*i+1]}));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(rx_ready), 64'd1);
        check("start_core_run", 64'(core_run), 64'd0);
        check("start_flags", 64'({done, error}), 64'd0);
        check("start_words", 64'(words_loaded), 64'd0);
        check("start_addr", 64'(imem_addr), 64'd0);
    endtask

    task automatic set_nominal();
        img[0] = 8'hA0; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] c;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        start    = 1'b0;
        use_gaps = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        reset = 1'b1;

        set_nominal();
        run_load(2, 8'h87);
        do_start();
        run_load(2, 8'h00);
        do_start();
        run_load(0, 8'h00);
        do_start();
        run_load(33, 8'h00);
        do_start();
        use_gaps = 1'b1;
        run_load(2, 8'h87);
        use_gaps = 1'b0;
        do_start();

        for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
        run_load(32, img_xor(32));

        do_start();
        set_nominal();
        got_q.delete();
        send_byte(8'd2);
        send_byte(8'hA0);
        send_byte(8'h01);
        rx_valid = 1'b0;
        check("wr_latency_we", 64'(imem_we), 64'd1);
        check("wr_latency_addr", 64'(imem_addr), 64'd0);
        check("wr_latency_data", 64'(imem_wdata), 64'hA001);
        @(negedge clk);
        check("mid_one_write", 64'(got_q.size()), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_reset_outs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("mid_reset_hold_outs", all_outs(), 64'd0);
        check("mid_reset_no_we", 64'(got_q.size()), 64'd1);
        reset = 1'b1;
        run_load(2, 8'h87);
        do_start();

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
            else
                n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
            c = (n >= 1 && n <= DEPTH) ? img_xor(n) : 8'd0;
            if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
            use_gaps = 1'($urandom_range(0, 1));
            run_load(n, c);
            do_start();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the multicycle core's instruction memory.
- Receives a program as a byte stream over a valid/ready interface and assembles the bytes into 16-bit instruction words.
- Writes each word into the instruction memory through a dedicated write port.
- Holds the core stopped (core_run low) until a complete, checksum-verified image is loaded; then releases it.

Parameters:
- DEPTH, 32, number of instruction-memory words; maximum program length.
- AW, 5, instruction-memory word-address width (log2 DEPTH).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- start  input  1  single-cycle pulse; restarts a load from DONE or ERROR.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  AW  instruction-memory word address.
- imem_wdata  output  16  instruction word to write.
- core_run  output  1  core may execute; high only in DONE.
- busy  output  1  load in progress (HDR, HI, LO, WR, CHK).
- done  output  1  image loaded and verified.
- error  output  1  load failed; sticky until start or reset.
- words_loaded  output  AW+1  count of words written in the current load.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - All outputs 0: rx_ready, imem_we, imem_addr, imem_wdata, core_run, busy, done, error, words_loaded.
  - Internal count, checksum and high-byte registers cleared.
- Byte transfer occurs on a posedge with rx_valid && rx_ready. rx_ready is a decode of state: 1 in HDR/HI/LO/CHK, 0 otherwise. rx_valid without rx_ready is ignored; the byte is not consumed.
- States: IDLE, HDR, HI, LO, WR, CHK, DONE, ERROR.
  - IDLE: next cycle -> HDR unconditionally. This is the first cycle after reset release.
  - HDR: accept count byte N.
    - N==0 or N>DEPTH -> ERROR.
    - Otherwise store N; clear checksum, imem_addr and words_loaded; -> HI.
  - HI: accept high byte; checksum ^= byte; -> LO.
  - LO: accept low byte; checksum ^= byte; imem_wdata <= {high,low}; -> WR.
  - WR: imem_we=1 for exactly this one cycle, with imem_addr and imem_wdata stable.
    - At the end of the cycle: words_loaded += 1.
    - If words_loaded+1==N -> CHK; else imem_addr += 1 -> HI.
  - CHK: accept checksum byte.
    - Equals running XOR -> DONE.
    - Otherwise -> ERROR.
  - DONE: done=1, core_run=1; start -> HDR.
  - ERROR: error=1, core_run=0; start -> HDR.
- start is ignored in IDLE/HDR/HI/LO/WR/CHK.
- On start from DONE/ERROR, on the next posedge: done, error and core_run drop to 0; words_loaded and imem_addr reset to 0.
- Write latency: imem_we rises in the cycle immediately after the posedge that accepted the low byte.
- Minimum cycles per word: 3 (HI, LO, WR).
- imem_addr never exceeds N-1, so there is no wrap-around; N==DEPTH writes addresses 0..DEPTH-1.
- Checksum: 8-bit XOR of all word bytes. The header and checksum bytes are excluded.
- Reset mid-load: aborts immediately; no further imem_we; memory contents already written are left unchanged; the loader restarts at IDLE.
- core_run never glitches high outside DONE. It falls in the same cycle the state leaves DONE.

Test Plan:
- Nominal load:
  - Stimulus: after reset, bytes 02 A0 01 12 34 87 with rx_valid held high.
  - Required response: imem_we pulses at addr 0 data A001, then addr 1 data 1234; words_loaded=2; done=1, core_run=1, error=0.
- Bad checksum:
  - Stimulus: same bytes with checksum 00.
  - Required response: both writes still occur; error=1, core_run=0, done=0; rx_ready=0 afterwards.
- Illegal header:
  - Stimulus: header 00, and separately header 21 (33).
  - Required response: ERROR on the next cycle; no imem_we; then a start pulse plus a valid load succeeds.
- Backpressure and gaps:
  - Stimulus: the nominal stream with rx_valid deasserted for random 1-5 cycle gaps, and rx_valid high during WR.
  - Required response: no byte dropped or duplicated; the WR cycle consumes no byte; identical writes and done=1.
- Full depth:
  - Stimulus: header 20 (32), 64 data bytes, correct XOR.
  - Required response: 32 writes at addresses 0..31 in order; words_loaded=32; done=1.
- Reset mid-load and restart:
  - Stimulus: assert reset after the first word's WR, then run a fresh nominal load.
  - Required response: all outputs 0 during reset; addr 0 is written again and loading ends in DONE. Also, a start pulse in DONE drops core_run the next cycle and returns the loader to HDR with rx_ready=1.
